// File: rtl/disp_source_if.sv
// rtl/disp_source_if.sv - debug-word capture and display-select bundle
interface disp_source_if;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        word_valid;
  logic [95:0] disp_reg;
  logic [1:0]  disp_ctrl;
  logic        frozen;

  modport master (
    output word0, word1, word2, word_valid,
    input  disp_reg, disp_ctrl, frozen
  );

  modport slave (
    input  word0, word1, word2, word_valid,
    output disp_reg, disp_ctrl, frozen
  );
endinterface

// File: rtl/disp_source.sv
// rtl/disp_source.sv - snapshot register, debounced page/freeze buttons and auto-scroll
// for the seven-segment display driver.
module disp_source #(
  parameter int DB_LIMIT      = 1000000,
  parameter int DB_W          = 20,
  parameter int SCROLL_CYCLES = 50000000,
  parameter int SCROLL_W      = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_mode,
  input  logic           btn_freeze,
  input  logic           sw_auto,
  disp_source_if.slave   bus
);

  typedef enum logic [1:0] {
    PG_W0    = 2'b01,
    PG_W1    = 2'b00,
    PG_W2    = 2'b10,
    PG_BLANK = 2'b11
  } page_t;

  localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DB_LIMIT - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_CYCLES - 1);

  // bit 0 = btn_mode, bit 1 = btn_freeze, bit 2 = sw_auto
  logic [2:0]          sync1_q, sync2_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          stable_prev_q;
  logic [DB_W-1:0]     db_cnt_q [2];
  logic [DB_W-1:0]     db_cnt_d [2];
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  page_t               page_q, page_d;
  logic                frozen_q, frozen_d;
  logic [95:0]         disp_q, disp_d;

  logic                mode_p, freeze_p, auto_on, scroll_tick;

  always_comb begin
    mode_p      = stable_q[0] & ~stable_prev_q[0];
    freeze_p    = stable_q[1] & ~stable_prev_q[1];
    auto_on     = sync2_q[2];
    scroll_tick = auto_on && (scroll_q == SCROLL_LAST);

    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end

    // A manual press restarts the period so a full page time follows it.
    scroll_d = (!auto_on || mode_p || scroll_tick) ? '0 : scroll_q + 1'b1;

    page_d = page_q;
    if (mode_p || scroll_tick) begin
      case (page_q)
        PG_W0:   page_d = PG_W1;
        PG_W1:   page_d = PG_W2;
        PG_W2:   page_d = PG_BLANK;
        default: page_d = PG_W0;
      endcase
    end

    frozen_d = frozen_q ^ freeze_p;
    // Uses the pre-toggle frozen value, so a coincident freeze press still captures.
    disp_d   = (!frozen_q && bus.word_valid) ? {bus.word2, bus.word1, bus.word0} : disp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q[0]   <= '0;
      db_cnt_q[1]   <= '0;
      scroll_q      <= '0;
      page_q        <= PG_W0;
      frozen_q      <= 1'b0;
      disp_q        <= '0;
    end else begin
      sync1_q       <= {sw_auto, btn_freeze, btn_mode};
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q[0]   <= db_cnt_d[0];
      db_cnt_q[1]   <= db_cnt_d[1];
      scroll_q      <= scroll_d;
      page_q        <= page_d;
      frozen_q      <= frozen_d;
      disp_q        <= disp_d;
    end
  end

  assign bus.disp_reg  = disp_q;
  assign bus.disp_ctrl = page_q;
  assign bus.frozen    = frozen_q;

endmodule

// File: doc/disp_source.md
Name: disp_source

Overview:
- Upstream feeder for the 8-digit seven-segment driver.
- Captures three 32-bit debug words from the core into a 96-bit display register: word0 at [31:0], word1 at [63:32], word2 at [95:64].
- Generates the 2-bit page select from a debounced push button or an auto-scroll timer.
- Supports a freeze button that holds the captured snapshot for inspection.

Parameters:
- DB_LIMIT, 1000000: consecutive stable cycles required before a debounced button level changes.
- DB_W, 20: width of each debounce counter; must satisfy 2^DB_W > DB_LIMIT.
- SCROLL_CYCLES, 50000000: auto-scroll page period in clk cycles.
- SCROLL_W, 26: width of the scroll counter; must satisfy 2^SCROLL_W ≥ SCROLL_CYCLES.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- btn_mode, input, 1: raw page-advance push button; asynchronous, bouncy.
- btn_freeze, input, 1: raw freeze-toggle push button; asynchronous, bouncy.
- sw_auto, input, 1: raw slide switch; 1 = auto-scroll enabled.
- word0, input, 32: debug word for page 2'b01.
- word1, input, 32: debug word for page 2'b00.
- word2, input, 32: debug word for page 2'b10.
- word_valid, input, 1: qualifies word0..word2 this cycle.
- disp_reg, output, 96: registered snapshot {word2, word1, word0}.
- disp_ctrl, output, 2: page select for the display driver.
- frozen, output, 1: 1 while the snapshot is held.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - disp_reg = 0, disp_ctrl = 2'b01, frozen = 0;
  - all synchroniser flops, debounced levels, debounce counters and the scroll counter = 0.
- Synchronisation: btn_mode, btn_freeze and sw_auto each pass through a 2-flop synchroniser. Nothing downstream uses the raw inputs.
- Debounce, per button:
  - If the synced level equals the stable level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DB_LIMIT-1 while the synced level still differs, the stable level takes the synced value and the counter clears.
  - Any glitch shorter than DB_LIMIT cycles causes no change.
- Edge detect: a rising edge of a stable level produces a 1-cycle pulse (mode_p, freeze_p). Falling edges produce nothing.
- Latency: a raw press held steady gives its pulse 2 + DB_LIMIT cycles after the raw edge (±1). The resulting disp_ctrl or frozen update is visible the cycle after the pulse.
- Page state machine (disp_ctrl):
  - Order: 01 → 00 → 10 → 11 (blank) → 01.
  - Advance condition: mode_p, or a scroll tick.
  - A mode_p and a scroll tick in the same cycle advance exactly one step.
- Auto-scroll:
  - While synced sw_auto = 1, the scroll counter increments each cycle.
  - At SCROLL_CYCLES-1 it emits a tick and wraps to 0.
  - mode_p clears the counter, so a full period follows every manual press.
  - While sw_auto = 0 the counter is held at 0 and no ticks occur.
- Freeze: freeze_p toggles frozen.
- Capture:
  - If frozen = 0 (value before any same-cycle toggle) and word_valid = 1, disp_reg loads {word2, word1, word0} on the next edge.
  - Otherwise disp_reg holds.
  - Consequence: a freeze press coinciding with word_valid still captures that cycle's words, then holds them.
- disp_ctrl, frozen and disp_reg are all registered outputs; none has a combinational path from any input.
- Reset mid-debounce or mid-scroll: all progress is discarded, with no pulses and no advance at reset release.

Test Plan (bench uses DB_LIMIT=4, DB_W=3, SCROLL_CYCLES=8, SCROLL_W=4):
- Reset/capture:
  - Assert rst mid-cycle → disp_reg = 0, disp_ctrl = 01, frozen = 0 immediately.
  - Release, then drive word0 = 0x12345678, word1 = 0xDEADBEEF, word2 = 0x0000CAFE with word_valid = 1 for 1 cycle → disp_reg = 0x0000CAFE_DEADBEEF_12345678 next cycle.
  - Drop word_valid and change the words → disp_reg unchanged.
- Debounce:
  - Toggle btn_mode high/low every 2 cycles for 20 cycles, then leave it low → disp_ctrl stays 01.
  - Then hold btn_mode high for 10 cycles → disp_ctrl = 00 exactly once, within 7 cycles of the edge.
- Page wrap: four clean btn_mode presses from reset → disp_ctrl sequence 00, 10, 11, 01.
- Freeze:
  - Press btn_freeze → frozen = 1; pulse word_valid with new words → disp_reg unchanged.
  - Press again → frozen = 0; the next word_valid captures.
  - Freeze pulse coincident with word_valid → those words are captured and frozen = 1.
- Auto-scroll:
  - sw_auto = 1 from reset → disp_ctrl advances every 8 cycles after the 2-cycle sync (01 → 00 → 10 → 11 → 01).
  - A btn_mode pulse landing on a tick cycle → single advance, and the next tick comes 8 cycles later.
  - sw_auto = 0 → advancing stops.
- Reset mid-operation: assert rst during a held btn_mode press (debounce count 2) with sw_auto = 1 → after release no advance occurs until a fresh full debounce or scroll period, and all outputs are at reset values.
